// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU result/flag retirement: SC update and 2-entry writeback queue
module alu_writeback #(
    parameter logic [7:0] SC_RESET = 8'hC0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_result,
    input  logic [3:0]  in_flags,
    input  logic [3:0]  in_flag_mask,
    input  logic        in_size,
    input  logic        in_write,
    input  logic [3:0]  in_dest,
    input  logic [15:0] in_dest_old,
    input  logic        sc_wr,
    input  logic [7:0]  sc_wdata,
    output logic [7:0]  sc,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [3:0]  wb_dest,
    output logic [15:0] wb_data
);

    logic [1:0]  count;
    logic        head;
    logic        tail;
    logic [3:0]  dest_q [2];
    logic [15:0] data_q [2];
    logic        acc;
    logic        push;
    logic        pop;
    logic [15:0] merged;

    // in_ready depends only on registered count, never on wb_ready
    assign in_ready = (count < 2'd2);
    assign wb_valid = (count != 2'd0);
    assign acc      = in_valid & in_ready;
    assign push     = acc & in_write;
    assign pop      = wb_valid & wb_ready;
    assign tail     = head ^ count[0];
    assign merged   = in_size ? in_result : {in_dest_old[15:8], in_result[7:0]};

    assign wb_dest  = wb_valid ? dest_q[head] : 4'd0;
    assign wb_data  = wb_valid ? data_q[head] : 16'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 2'd0;
            head  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                dest_q[i] <= 4'd0;
                data_q[i] <= 16'd0;
            end
        end else begin
            if (push) begin
                dest_q[tail] <= in_dest;
                data_q[tail] <= merged;
            end
            if (pop)
                head <= ~head;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // A direct SC write overrides any same-cycle ALU flag update
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sc <= SC_RESET;
        else if (sc_wr)
            sc <= sc_wdata;
        else if (acc)
            sc <= {sc[7:4], (in_flag_mask & in_flags) | (~in_flag_mask & sc[3:0])};
    end

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - vector table plus scoreboard bench for alu_writeback
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_result = '0;
    logic [3:0]  in_flags = '0;
    logic [3:0]  in_flag_mask = '0;
    logic        in_size = 1'b0;
    logic        in_write = 1'b0;
    logic [3:0]  in_dest = '0;
    logic [15:0] in_dest_old = '0;
    logic        sc_wr = 1'b0;
    logic [7:0]  sc_wdata = '0;
    logic [7:0]  sc;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [3:0]  wb_dest;
    logic [15:0] wb_data;

    logic        in_ready2;
    logic [7:0]  sc2;
    logic        wb_valid2;
    logic [3:0]  wb_dest2;
    logic [15:0] wb_data2;

    alu_writeback dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_flag_mask(in_flag_mask),
        .in_size(in_size), .in_write(in_write), .in_dest(in_dest),
        .in_dest_old(in_dest_old), .sc_wr(sc_wr), .sc_wdata(sc_wdata), .sc(sc),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest), .wb_data(wb_data)
    );

    alu_writeback #(.SC_RESET(8'h00)) dut_zero (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_result(in_result), .in_flags(in_flags), .in_flag_mask(in_flag_mask),
        .in_size(in_size), .in_write(in_write), .in_dest(in_dest),
        .in_dest_old(in_dest_old), .sc_wr(sc_wr), .sc_wdata(sc_wdata), .sc(sc2),
        .wb_valid(wb_valid2), .wb_ready(wb_ready), .wb_dest(wb_dest2), .wb_data(wb_data2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic        size;
        logic [15:0] result;
        logic [15:0] old;
        logic [3:0]  dest;
        logic [3:0]  flags;
        logic [3:0]  mask;
        logic        scw;
        logic [7:0]  swd;
        logic [7:0]  exp_sc;
        logic [15:0] exp_data;
    } vec_t;

    vec_t        tbl [8];
    logic [19:0] sb [$];
    logic [15:0] popped [$];
    int          model_count = 0;
    logic [7:0]  model_sc = 8'hC0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Checks head/ready against the model, then advances one clock edge
    task automatic cycle(input string tag);
        bit          acc, push, pop;
        logic [15:0] m;
        chk({tag, " in_ready"}, 32'(in_ready), 32'(model_count < 2));
        chk({tag, " wb_valid"}, 32'(wb_valid), 32'(model_count != 0));
        if (model_count != 0 && sb.size() > 0) begin
            chk({tag, " wb_dest"}, 32'(wb_dest), 32'(sb[0][19:16]));
            chk({tag, " wb_data"}, 32'(wb_data), 32'(sb[0][15:0]));
        end else begin
            chk({tag, " wb_data idle"}, 32'(wb_data), 32'd0);
        end
        acc  = in_valid && (model_count < 2);
        push = acc && in_write;
        pop  = (model_count != 0) && wb_ready;
        m    = in_size ? in_result : {in_dest_old[15:8], in_result[7:0]};
        if (pop && sb.size() > 0) begin
            popped.push_back(sb[0][15:0]);
            void'(sb.pop_front());
        end
        if (push) sb.push_back({in_dest, m});
        model_count = model_count + int'(push) - int'(pop);
        if (sc_wr) model_sc = sc_wdata;
        else if (acc) model_sc[3:0] = (in_flag_mask & in_flags) | (~in_flag_mask & model_sc[3:0]);
        @(posedge clk);
        #1;
        chk({tag, " sc"}, 32'(sc), 32'(model_sc));
    endtask

    task automatic drive(input logic v, input logic w, input logic sz, input logic [15:0] r,
                         input logic [3:0] d, input logic [3:0] f, input logic [3:0] mk);
        in_valid = v; in_write = w; in_size = sz; in_result = r; in_dest = d;
        in_flags = f; in_flag_mask = mk; in_dest_old = 16'h0000; sc_wr = 1'b0;
    endtask

    task automatic drain();
        drive(0, 0, 0, 16'h0, 4'h0, 4'h0, 4'h0);
        wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle("drain");
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 16'hAB12, 16'h3456, 4'd2, 4'h0, 4'h0, 1'b0, 8'h00, 8'hC0, 16'h3412};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 16'hAB12, 16'h3456, 4'd2, 4'h0, 4'h0, 1'b0, 8'h00, 8'hC0, 16'hAB12};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 4'hF, 4'h3, 1'b0, 8'h00, 8'hC3, 16'h0000};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 4'd0, 4'hF, 4'hF, 1'b1, 8'h10, 8'h10, 16'h0000};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 4'd7, 4'h0, 4'hF, 1'b0, 8'h00, 8'h10, 16'h0000};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 4'h0, 4'h0, 1'b1, 8'hC0, 8'hC0, 16'h0000};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 4'hA, 4'hE, 1'b0, 8'h00, 8'hCA, 16'h0000};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 16'h5555, 16'h0000, 4'd9, 4'hF, 4'hF, 1'b0, 8'h00, 8'hCA, 16'h0000};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset sc", 32'(sc), 32'hC0);
        chk("reset sc override", 32'(sc2), 32'h00);
        chk("reset wb_valid", 32'(wb_valid), 32'd0);
        chk("reset wb_dest", 32'(wb_dest), 32'd0);
        chk("reset wb_data", 32'(wb_data), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].valid, tbl[i].write, tbl[i].size, tbl[i].result,
                  tbl[i].dest, tbl[i].flags, tbl[i].mask);
            in_dest_old = tbl[i].old;
            sc_wr = tbl[i].scw;
            sc_wdata = tbl[i].swd;
            cycle("vec");
            chk($sformatf("vec%0d sc", i), 32'(sc), 32'(tbl[i].exp_sc));
            if (tbl[i].valid && tbl[i].write) begin
                chk($sformatf("vec%0d wb_valid", i), 32'(wb_valid), 32'd1);
                chk($sformatf("vec%0d wb_dest", i), 32'(wb_dest), 32'(tbl[i].dest));
                chk($sformatf("vec%0d wb_data", i), 32'(wb_data), 32'(tbl[i].exp_data));
            end else begin
                chk($sformatf("vec%0d no push", i), 32'(wb_valid), 32'd0);
            end
        end
        drain();

        // Backpressure: third result must wait until the first pop frees a slot
        popped.delete();
        wb_ready = 1'b0;
        drive(1, 1, 1, 16'd1, 4'd1, 4'h0, 4'hF); cycle("bp1");
        drive(1, 1, 1, 16'd2, 4'd2, 4'h0, 4'hF); cycle("bp2");
        chk("bp full in_ready", 32'(in_ready), 32'd0);
        drive(1, 1, 1, 16'd3, 4'd3, 4'hF, 4'hF);
        for (int i = 0; i < 3; i++) cycle("bp hold");
        chk("bp held sc", 32'(sc), 32'hC0);
        wb_ready = 1'b1;
        cycle("bp pop1");
        chk("bp in_ready after pop", 32'(in_ready), 32'd1);
        cycle("bp push3");
        drain();
        chk("bp popped count", 32'(popped.size()), 32'd3);
        for (int i = 0; i < 3 && i < popped.size(); i++)
            chk($sformatf("bp order%0d", i), 32'(popped[i]), 32'(i + 1));

        // Push and pop together at count=1: new entry becomes head
        wb_ready = 1'b0;
        drive(1, 1, 1, 16'd5, 4'd5, 4'h0, 4'h0); cycle("pp push5");
        wb_ready = 1'b1;
        drive(1, 1, 1, 16'd6, 4'd6, 4'h0, 4'h0); cycle("pp push6");
        chk("pp head", 32'(wb_data), 32'd6);
        chk("pp valid", 32'(wb_valid), 32'd1);
        drain();

        // Asynchronous reset with two entries queued
        wb_ready = 1'b0;
        drive(1, 1, 1, 16'h77, 4'd7, 4'hF, 4'hF); cycle("rs a");
        drive(1, 1, 1, 16'h88, 4'd8, 4'hF, 4'hF); cycle("rs b");
        drive(0, 0, 0, 16'h0, 4'h0, 4'h0, 4'h0);
        chk("rs full", 32'(in_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("rs async wb_valid", 32'(wb_valid), 32'd0);
        chk("rs async in_ready", 32'(in_ready), 32'd1);
        chk("rs async sc", 32'(sc), 32'hC0);
        chk("rs async sc override", 32'(sc2), 32'h00);
        sb.delete();
        model_count = 0;
        model_sc = 8'hC0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wb_ready = 1'b1;
        cycle("rs idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
